// File: rtl/m68k_bus_responder.sv
// 68000 bus-cycle responder: turns decoder chip selects into DTACK/BERR with
// per-region wait states, the program-ROM SDRAM handshake and shared-RAM claim.
module m68k_bus_responder #(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned PAL_WAIT = 2,
  parameter int unsigned REG_WAIT = 0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_as_n,
  input  logic        prog_rom_cs,
  input  logic        ram_cs,
  input  logic        shared_ram_cs,
  input  logic        pal_cs,
  input  logic        reg_cs,
  input  logic        prog_rom_ready,
  input  logic [15:0] prog_rom_din,
  input  logic        shared_ram_busy,
  output logic        prog_rom_req,
  output logic [15:0] prog_rom_dout,
  output logic        shared_ram_grant,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_WAIT,
    S_ROM_WAIT,
    S_SHARED,
    S_ACK,
    S_BERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             has_src;
  logic             tmo_hit_c;

  // >= keeps the timeout reachable even if the counter stepped past TIMEOUT-1
  // while a grant was being set up in SHARED.
  assign tmo_hit_c = (tmo_cnt >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_DRAIN;
      wait_cnt         <= '0;
      tmo_cnt          <= '0;
      has_src          <= 1'b0;
      prog_rom_req     <= 1'b0;
      prog_rom_dout    <= '0;
      shared_ram_grant <= 1'b0;
      cpu_dtack_n      <= 1'b1;
      cpu_berr_n       <= 1'b1;
    end else begin
      prog_rom_req <= 1'b0;
      case (state)
        // A cycle already running at reset release is left unanswered.
        S_DRAIN: begin
          if (cpu_as_n) state <= S_IDLE;
        end

        S_IDLE: begin
          if (!cpu_as_n) begin
            tmo_cnt <= '0;
            if (prog_rom_cs) begin
              state        <= S_ROM_WAIT;
              prog_rom_req <= 1'b1;
            end else if (ram_cs) begin
              state    <= S_WAIT;
              wait_cnt <= CNT_W'(RAM_WAIT);
              has_src  <= 1'b1;
            end else if (shared_ram_cs) begin
              state <= S_SHARED;
            end else if (pal_cs) begin
              state    <= S_WAIT;
              wait_cnt <= CNT_W'(PAL_WAIT);
              has_src  <= 1'b1;
            end else if (reg_cs) begin
              state    <= S_WAIT;
              wait_cnt <= CNT_W'(REG_WAIT);
              has_src  <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= '0;
              has_src  <= 1'b0;
            end
          end
        end

        S_WAIT: begin
          if (cpu_as_n) begin
            state            <= S_IDLE;
            shared_ram_grant <= 1'b0;
          end else if (has_src && wait_cnt == '0) begin
            state       <= S_ACK;
            cpu_dtack_n <= 1'b0;
          end else if (tmo_hit_c) begin
            state      <= S_BERR;
            cpu_berr_n <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        S_ROM_WAIT: begin
          if (cpu_as_n) begin
            state <= S_IDLE;
          end else if (prog_rom_ready) begin
            state         <= S_ACK;
            prog_rom_dout <= prog_rom_din;
            cpu_dtack_n   <= 1'b0;
          end else if (tmo_hit_c) begin
            state      <= S_BERR;
            cpu_berr_n <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        S_SHARED: begin
          if (cpu_as_n) begin
            state <= S_IDLE;
          end else if (!shared_ram_busy) begin
            state            <= S_WAIT;
            shared_ram_grant <= 1'b1;
            wait_cnt         <= CNT_W'(RAM_WAIT);
            has_src          <= 1'b1;
            tmo_cnt          <= tmo_cnt + CNT_W'(1);
          end else if (tmo_hit_c) begin
            state      <= S_BERR;
            cpu_berr_n <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        S_ACK: begin
          if (cpu_as_n) begin
            state            <= S_IDLE;
            cpu_dtack_n      <= 1'b1;
            shared_ram_grant <= 1'b0;
          end
        end

        S_BERR: begin
          if (cpu_as_n) begin
            state            <= S_IDLE;
            cpu_berr_n       <= 1'b1;
            shared_ram_grant <= 1'b0;
          end
        end

        default: begin
          state       <= S_DRAIN;
          cpu_dtack_n <= 1'b1;
          cpu_berr_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: stimulus queues expected output
// transitions with their edge number; a negedge monitor pops and compares them.
module tb_m68k_bus_responder;

  localparam int EV_REQ_RISE   = 0;
  localparam int EV_REQ_FALL   = 1;
  localparam int EV_GNT_RISE   = 2;
  localparam int EV_GNT_FALL   = 3;
  localparam int EV_DTACK_FALL = 4;
  localparam int EV_DTACK_RISE = 5;
  localparam int EV_BERR_FALL  = 6;
  localparam int EV_BERR_RISE  = 7;

  typedef struct {
    int          kind;
    int          at_edge;
    logic [15:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_as_n;
  logic        prog_rom_cs, ram_cs, shared_ram_cs, pal_cs, reg_cs;
  logic        prog_rom_ready;
  logic [15:0] prog_rom_din;
  logic        shared_ram_busy;
  logic        prog_rom_req;
  logic [15:0] prog_rom_dout;
  logic        shared_ram_grant;
  logic        cpu_dtack_n;
  logic        cpu_berr_n;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_no = 0;
  logic [15:0] dout_exp = 16'h0000;
  logic        mon_en = 1'b0;
  logic        req_p, gnt_p, dtack_p, berr_p;

  m68k_bus_responder #(
    .RAM_WAIT(1), .PAL_WAIT(2), .REG_WAIT(0), .TIMEOUT(64)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_as_n        (cpu_as_n),
    .prog_rom_cs     (prog_rom_cs),
    .ram_cs          (ram_cs),
    .shared_ram_cs   (shared_ram_cs),
    .pal_cs          (pal_cs),
    .reg_cs          (reg_cs),
    .prog_rom_ready  (prog_rom_ready),
    .prog_rom_din    (prog_rom_din),
    .shared_ram_busy (shared_ram_busy),
    .prog_rom_req    (prog_rom_req),
    .prog_rom_dout   (prog_rom_dout),
    .shared_ram_grant(shared_ram_grant),
    .cpu_dtack_n     (cpu_dtack_n),
    .cpu_berr_n      (cpu_berr_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no++;

  function automatic string ev_name(input int k);
    case (k)
      EV_REQ_RISE:   return "req_rise";
      EV_REQ_FALL:   return "req_fall";
      EV_GNT_RISE:   return "grant_rise";
      EV_GNT_FALL:   return "grant_fall";
      EV_DTACK_FALL: return "dtack_fall";
      EV_DTACK_RISE: return "dtack_rise";
      EV_BERR_FALL:  return "berr_fall";
      default:       return "berr_rise";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic push(input int kind, input int at_e);
    exp_t e;
    e.kind = kind;
    e.at_edge = at_e;
    e.dout = dout_exp;
    q.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s: seen at edge %0d, none expected", ev_name(kind), edge_no);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at_edge != edge_no) begin
        errors++;
        $display("FAIL event: got %s at edge %0d expected %s at edge %0d",
                 ev_name(kind), edge_no, ev_name(e.kind), e.at_edge);
      end
      if (kind == EV_DTACK_FALL) check("rom_dout_at_dtack", 32'(prog_rom_dout), 32'(e.dout));
    end
  endtask

  // Monitor: detect output transitions after each active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (req_p === 1'b0 && prog_rom_req === 1'b1)     observe(EV_REQ_RISE);
      if (req_p === 1'b1 && prog_rom_req === 1'b0)     observe(EV_REQ_FALL);
      if (gnt_p === 1'b0 && shared_ram_grant === 1'b1) observe(EV_GNT_RISE);
      if (gnt_p === 1'b1 && shared_ram_grant === 1'b0) observe(EV_GNT_FALL);
      if (dtack_p === 1'b1 && cpu_dtack_n === 1'b0)    observe(EV_DTACK_FALL);
      if (dtack_p === 1'b0 && cpu_dtack_n === 1'b1)    observe(EV_DTACK_RISE);
      if (berr_p === 1'b1 && cpu_berr_n === 1'b0)      observe(EV_BERR_FALL);
      if (berr_p === 1'b0 && cpu_berr_n === 1'b1)      observe(EV_BERR_RISE);
      check("dtack_berr_exclusive", 32'(cpu_dtack_n | cpu_berr_n), 32'd1);
    end
    req_p   = prog_rom_req;
    gnt_p   = shared_ram_grant;
    dtack_p = cpu_dtack_n;
    berr_p  = cpu_berr_n;
  end

  // Position at the negedge just before edge e, so drives are sampled at e.
  task automatic at(input int e);
    while (edge_no < e - 1) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_n = 1'b0;
    cpu_as_n = 1'b1;
    {prog_rom_cs, ram_cs, shared_ram_cs, pal_cs, reg_cs} = '0;
    prog_rom_ready = 1'b0;
    prog_rom_din = 16'h0000;
    shared_ram_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dtack_n", 32'(cpu_dtack_n), 32'd1);
    check("reset_berr_n", 32'(cpu_berr_n), 32'd1);
    check("reset_req", 32'(prog_rom_req), 32'd0);
    check("reset_grant", 32'(shared_ram_grant), 32'd0);
    check("reset_dout", 32'(prog_rom_dout), 32'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Register access, zero wait states
    b = edge_no + 1;
    cpu_as_n = 1'b0; reg_cs = 1'b1;
    push(EV_DTACK_FALL, b + 1);
    at(b + 4); cpu_as_n = 1'b1; reg_cs = 1'b0;
    push(EV_DTACK_RISE, b + 4);

    // ROM fetch, accepted straight after the previous release
    b = b + 5;
    at(b); cpu_as_n = 1'b0; prog_rom_cs = 1'b1;
    push(EV_REQ_RISE, b); push(EV_REQ_FALL, b + 1);
    at(b + 7); prog_rom_ready = 1'b1; prog_rom_din = 16'hBEEF;
    dout_exp = 16'hBEEF;
    push(EV_DTACK_FALL, b + 7);
    at(b + 8); prog_rom_ready = 1'b0; prog_rom_din = 16'h0000;
    at(b + 10); cpu_as_n = 1'b1; prog_rom_cs = 1'b0;
    push(EV_DTACK_RISE, b + 10);

    // Shared RAM with Z80 contention
    b = b + 13;
    at(b); cpu_as_n = 1'b0; shared_ram_cs = 1'b1; shared_ram_busy = 1'b1;
    at(b + 6); shared_ram_busy = 1'b0;
    push(EV_GNT_RISE, b + 6); push(EV_DTACK_FALL, b + 8);
    at(b + 10); cpu_as_n = 1'b1; shared_ram_cs = 1'b0;
    push(EV_GNT_FALL, b + 10); push(EV_DTACK_RISE, b + 10);

    // Unmapped access times out
    b = b + 13;
    at(b); cpu_as_n = 1'b0;
    push(EV_BERR_FALL, b + 64);
    at(b + 66); cpu_as_n = 1'b1;
    push(EV_BERR_RISE, b + 66);

    // ROM fetch with no ready times out
    b = b + 69;
    at(b); cpu_as_n = 1'b0; prog_rom_cs = 1'b1;
    push(EV_REQ_RISE, b); push(EV_REQ_FALL, b + 1); push(EV_BERR_FALL, b + 64);
    at(b + 65); cpu_as_n = 1'b1; prog_rom_cs = 1'b0;
    push(EV_BERR_RISE, b + 65);

    // RAM beats PAL
    b = b + 68;
    at(b); cpu_as_n = 1'b0; ram_cs = 1'b1; pal_cs = 1'b1;
    push(EV_DTACK_FALL, b + 2);
    at(b + 4); cpu_as_n = 1'b1; ram_cs = 1'b0; pal_cs = 1'b0;
    push(EV_DTACK_RISE, b + 4);

    // PAL access aborted after one edge
    b = b + 6;
    at(b); cpu_as_n = 1'b0; pal_cs = 1'b1;
    at(b + 1); cpu_as_n = 1'b1; pal_cs = 1'b0;

    // Aborted ROM fetch followed by a late ready pulse
    b = b + 6;
    at(b); cpu_as_n = 1'b0; prog_rom_cs = 1'b1;
    push(EV_REQ_RISE, b); push(EV_REQ_FALL, b + 1);
    at(b + 3); cpu_as_n = 1'b1; prog_rom_cs = 1'b0;
    at(b + 5); prog_rom_ready = 1'b1; prog_rom_din = 16'h1234;
    at(b + 6); prog_rom_ready = 1'b0; prog_rom_din = 16'h0000;
    at(b + 8);
    check("rom_dout_after_abort", 32'(prog_rom_dout), 32'hBEEF);

    // Register access confirms the ROM latch kept its value
    b = b + 9;
    at(b); cpu_as_n = 1'b0; reg_cs = 1'b1;
    push(EV_DTACK_FALL, b + 1);
    at(b + 3); cpu_as_n = 1'b1; reg_cs = 1'b0;
    push(EV_DTACK_RISE, b + 3);

    // Reset in the middle of a PAL wait, AS held low across it
    b = b + 6;
    at(b); cpu_as_n = 1'b0; pal_cs = 1'b1;
    at(b + 3); reset_n = 1'b0;
    at(b + 4);
    check("midreset_dtack_n", 32'(cpu_dtack_n), 32'd1);
    check("midreset_dout", 32'(prog_rom_dout), 32'd0);
    check("midreset_grant", 32'(shared_ram_grant), 32'd0);
    dout_exp = 16'h0000;
    reset_n = 1'b1;
    at(b + 8); cpu_as_n = 1'b1; pal_cs = 1'b0;
    at(b + 10); cpu_as_n = 1'b0; reg_cs = 1'b1;
    push(EV_DTACK_FALL, b + 11);
    at(b + 13); cpu_as_n = 1'b1; reg_cs = 1'b0;
    push(EV_DTACK_RISE, b + 13);

    at(b + 20);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
